// File: rtl/qosc_pkg.sv
// Shared types and default sizing for the quadrature oscillator sample streamer.
package qosc_pkg;

    localparam int QOSC_DATA_W     = 8;
    localparam int QOSC_FIFO_DEPTH = 4;
    localparam int QOSC_CLK_DIV    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } stream_state_e;

    typedef struct packed {
        logic [QOSC_DATA_W-1:0] re;
        logic [QOSC_DATA_W-1:0] im;
    } sample_pair_t;

endpackage

// File: rtl/qosc_sample_fifo.sv
// Synchronous FIFO for captured sample pairs; full/empty come from an extra pointer bit.
module qosc_sample_fifo
    import qosc_pkg::*;
#(
    parameter int WIDTH = 2 * QOSC_DATA_W,
    parameter int DEPTH = QOSC_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/qosc_sample_streamer.sv
// Captures oscillator sample pairs into a FIFO and streams them out as framed serial words.
//
//   state    | meaning
//   ST_IDLE  | serial outputs low, waiting for a queued pair
//   ST_LOAD  | one cycle: pop head pair into the shift register
//   ST_SHIFT | frame high, one bit per 2*CLK_DIV cycles, MSB first
//   ST_GAP   | 2*CLK_DIV idle cycles between frames
module qosc_sample_streamer
    import qosc_pkg::*;
#(
    parameter int DATA_W     = QOSC_DATA_W,
    parameter int FIFO_DEPTH = QOSC_FIFO_DEPTH,
    parameter int CLK_DIV    = QOSC_CLK_DIV,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_re,
    input  logic [DATA_W-1:0] sample_im,
    output logic              ser_clk,
    output logic              ser_data,
    output logic              ser_frame,
    output logic              overflow,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int FRAME_W = 2 * DATA_W;
    localparam int CNT_W   = $clog2(2 * CLK_DIV);
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF    = CNT_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(FRAME_W - 1);

    stream_state_e       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [FRAME_W-1:0]  fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                push;
    logic                frame_d;
    logic                data_d;
    logic                sclk_d;
    logic                overflow_d;

    assign pop  = (state_q == ST_LOAD);
    assign push = sample_valid && enable;

    qosc_sample_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({sample_re, sample_im}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d = fifo_dout;
                cnt_d   = CNT_MAX;
                bit_d   = BIT_MAX;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    cnt_d   = CNT_MAX;
                    if (bit_q == '0) state_d = ST_GAP;
                    else             bit_d   = bit_q - 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Serial pins are registered from next-state values so they line up with the state.
        frame_d = (state_d == ST_SHIFT);
        data_d  = frame_d && shift_d[FRAME_W-1];
        sclk_d  = frame_d && (cnt_d < HALF);

        overflow_d = overflow;
        if (!enable)                                 overflow_d = 1'b0;
        else if (sample_valid && fifo_full && !pop)  overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_clk   <= 1'b0;
            ser_data  <= 1'b0;
            ser_frame <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ser_clk   <= sclk_d;
            ser_data  <= data_d;
            ser_frame <= frame_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_qosc_sample_streamer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based frame model.
module tb_qosc_sample_streamer;
    import qosc_pkg::*;

    localparam int DW        = 8;
    localparam int DEPTH     = 4;
    localparam int CD        = 2;
    localparam int BIT_CYC   = 2 * CD;
    localparam int FRAME_CYC = 2 * DW * BIT_CYC;
    localparam int PERIOD    = 1 + FRAME_CYC + BIT_CYC;

    logic          clk;
    logic          rst_n;
    logic          en, sv;
    logic [DW-1:0] re, im;
    logic          ser_clk, ser_data, ser_frame, overflow;
    logic [2:0]    fifo_level;

    logic          sv2;
    logic [DW-1:0] re2, im2;
    logic          ser_clk2, ser_data2, ser_frame2, overflow2;
    logic [2:0]    fifo_level2;

    qosc_sample_streamer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(CD)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(en), .sample_valid(sv),
        .sample_re(re), .sample_im(im), .ser_clk(ser_clk), .ser_data(ser_data),
        .ser_frame(ser_frame), .overflow(overflow), .fifo_level(fifo_level)
    );

    qosc_sample_streamer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(1)) u_dut_cd1 (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .sample_valid(sv2),
        .sample_re(re2), .sample_im(im2), .ser_clk(ser_clk2), .ser_data(ser_data2),
        .ser_frame(ser_frame2), .overflow(overflow2), .fifo_level(fifo_level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: queued pairs, the pair currently on the wire and when it was loaded.
    sample_pair_t q[$];
    sample_pair_t cur_val;
    int           cur_load = -1000;
    int           earliest = 0;
    int           sz_prev  = 0;
    bit           m_ovf    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] exp_ser();
        int k;
        int b;
        k = cyc - cur_load - 1;
        if (k < 0 || k >= FRAME_CYC) return 3'b000;
        b = k / BIT_CYC;
        return {((k % BIT_CYC) >= CD), cur_val[2*DW-1-b], 1'b1};
    endfunction

    task automatic model_reset();
        q.delete();
        cur_load = -1000;
        earliest = 0;
        sz_prev  = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic tick();
        bit ld, do_push, full;
        ld = 1'b0;
        do_push = 1'b0;
        if (rst_n) begin
            ld      = (cyc >= earliest) && (sz_prev > 0);
            sz_prev = q.size();
            full    = (q.size() == DEPTH);
            do_push = sv && en && (!full || ld);
            if (!en)                     m_ovf = 1'b0;
            else if (sv && full && !ld)  m_ovf = 1'b1;
        end
        @(posedge clk);
        if (ld) begin
            cur_val  = q.pop_front();
            cur_load = cyc;
            earliest = cyc + PERIOD;
        end
        if (do_push) q.push_back({re, im});
        cyc++;
        #1;
        chk("ser", {29'd0, ser_clk, ser_data, ser_frame}, {29'd0, exp_ser()});
        chk("lvl", {29'd0, fifo_level}, q.size());
        chk("ovf", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic pulse(input logic [DW-1:0] r, input logic [DW-1:0] i);
        sv = 1'b1; re = r; im = i;
        tick();
        sv = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int first, len, n0;
        logic [15:0] bits;
        logic prev_clk;

        rst_n = 1'b0; en = 1'b0; sv = 1'b0; re = '0; im = '0;
        sv2 = 1'b0; re2 = '0; im2 = '0;
        idle(3);
        rst_n = 1'b1;
        en = 1'b1;
        idle(2);

        // single sample
        pulse(8'h7D, 8'h1B);
        idle(80);

        // spaced samples
        pulse(8'h20, 8'h00); idle(99);
        pulse(8'h1F, 8'h06); idle(99);
        pulse(8'h1C, 8'h0C); idle(100);

        // overflow burst, then clear via enable
        for (int v = 1; v <= 6; v++) pulse(DW'(v), DW'(v));
        idle(5 * PERIOD);
        en = 1'b0; tick(); en = 1'b1; idle(3);

        // enable gating
        en = 1'b0;
        for (int v = 0; v < 3; v++) pulse(8'hA0 + DW'(v), 8'h55);
        idle(20);
        en = 1'b1;
        for (int v = 0; v < 3; v++) pulse(8'hC0 + DW'(v), 8'h3C);
        idle(10);
        en = 1'b0;
        idle(3 * PERIOD + 20);
        en = 1'b1;

        // reset in the middle of bit 7 with overflow set and entries queued
        for (int v = 0; v < 6; v++) pulse(8'h31 + DW'(v), 8'hE0 + DW'(v));
        for (int i = 0; i < 200 && cyc < cur_load + 30; i++) tick();
        chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ser", {29'd0, ser_clk, ser_data, ser_frame}, 32'd0);
        chk("rst_lvl", {29'd0, fifo_level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        idle(2);
        pulse(8'h96, 8'h69);
        idle(80);

        // CLK_DIV=1 instance
        n0 = cyc;
        sv2 = 1'b1; re2 = 8'hFF; im2 = 8'h00;
        tick();
        sv2 = 1'b0;
        first = -1; len = 0; bits = '0; prev_clk = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ser_frame2) begin
                if (first < 0) first = cyc;
                len++;
                chk("cd1_clk", {31'd0, ser_clk2}, (cyc - first) % 2);
                if (ser_clk2 && !prev_clk) bits = {bits[14:0], ser_data2};
            end
            prev_clk = ser_clk2;
        end
        chk("cd1_start", first, n0 + 3);
        chk("cd1_len", len, 32);
        chk("cd1_bits", {16'd0, bits}, 32'h0000FF00);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 24) != 0);
            sv = ($urandom_range(0, 9) == 0);
            re = DW'($urandom);
            im = DW'($urandom);
            tick();
        end
        sv = 1'b0; en = 1'b1;
        idle(DEPTH * PERIOD + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
